// File: rtl/entropy_whitener.sv
// entropy_whitener: TRNG post-processor; samples a synchronised raw bit on sample_En,
// whitens it (DEPTH-sample XOR parity or von Neumann pairs), packs bits LSB-first into
// WIDTH-bit words behind valid/ready, and flags stuck sources with a repetition count.
// Ports: clk/reset (sync, active-high); raw_In async entropy bit; sample_En strobe;
// mode 0=parity 1=von Neumann; out_Ready/out_Valid/out_Data word handshake;
// overflow sticky dropped-word flag; health_Fail sticky repetition-limit flag.
module entropy_whitener #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_In,
  input  logic             sample_En,
  input  logic             mode,
  input  logic             out_Ready,
  output logic             out_Valid,
  output logic [WIDTH-1:0] out_Data,
  output logic             overflow,
  output logic             health_Fail
);
  localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(WIDTH);
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic             r_s1, r_s2, r_mode_q, r_acc, r_vn_have, r_vn_first, r_last;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_pcnt;
  logic [WIDTH-1:0] r_pack;
  logic [RW-1:0]    r_rep;

  logic             w_chg, w_take, w_par_end, w_bit_v, w_bit, w_done, w_xfer, w_load;
  logic [RW-1:0]    w_rep_nx;
  logic [WIDTH-1:0] w_word;

  // A mode change discards that cycle's sample and restarts all whitening state.
  assign w_chg     = mode != r_mode_q;
  assign w_take    = sample_En & ~w_chg;
  assign w_par_end = r_cnt == CW'(DEPTH - 1);
  assign w_bit_v   = w_take & (r_mode_q ? r_vn_have & (r_vn_first != r_s2) : w_par_end);
  // Von Neumann: (0,1)->0 and (1,0)->1, i.e. the first sample of an unequal pair.
  assign w_bit     = r_mode_q ? r_vn_first : r_acc ^ r_s2;
  assign w_done    = w_bit_v & (r_pcnt == PW'(WIDTH - 1));
  assign w_word    = {w_bit, r_pack[WIDTH-2:0]};
  assign w_xfer    = out_Valid & out_Ready;
  assign w_load    = w_done & ~health_Fail & (~out_Valid | w_xfer);
  // r_rep==0 only before the first sample after reset, so that sample starts a run.
  assign w_rep_nx  = (r_rep == '0 || r_s2 != r_last) ? RW'(1) :
                     (r_rep == RW'(REP_LIMIT) ? r_rep : r_rep + RW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_mode_q    <= 1'b0;
      r_acc       <= 1'b0;
      r_cnt       <= '0;
      r_vn_have   <= 1'b0;
      r_vn_first  <= 1'b0;
      r_last      <= 1'b0;
      r_rep       <= '0;
      r_pcnt      <= '0;
      r_pack      <= '0;
      out_Valid   <= 1'b0;
      out_Data    <= '0;
      overflow    <= 1'b0;
      health_Fail <= 1'b0;
    end else begin
      r_s1     <= raw_In;
      r_s2     <= r_s1;
      r_mode_q <= mode;
      if (w_chg) begin
        r_acc     <= 1'b0;
        r_cnt     <= '0;
        r_vn_have <= 1'b0;
        r_pcnt    <= '0;
        r_pack    <= '0;
      end else if (sample_En) begin
        r_last <= r_s2;
        r_rep  <= w_rep_nx;
        if (w_rep_nx == RW'(REP_LIMIT)) health_Fail <= 1'b1;
        if (r_mode_q) begin
          r_vn_have  <= ~r_vn_have;
          r_vn_first <= r_s2;
        end else begin
          r_acc <= w_par_end ? 1'b0 : r_acc ^ r_s2;
          r_cnt <= w_par_end ? '0 : r_cnt + CW'(1);
        end
        if (w_bit_v) begin
          r_pcnt <= w_done ? '0 : r_pcnt + PW'(1);
          r_pack <= w_done ? '0 : r_pack | (WIDTH'(w_bit) << r_pcnt);
        end
      end
      if (w_load) begin
        out_Data  <= w_word;
        out_Valid <= 1'b1;
      end else begin
        if (w_xfer) out_Valid <= 1'b0;
        if (w_done & ~health_Fail) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_entropy_whitener.sv
// tb_entropy_whitener: directed table plus corner sequences for entropy_whitener.
module tb_entropy_whitener;
  logic       clk = 1'b0, reset = 1'b1, raw_In = 1'b0, sample_En = 1'b0, mode = 1'b0, out_Ready = 1'b1;
  logic       out_Valid, overflow, health_Fail;
  logic [7:0] out_Data;
  logic [7:0] q[$];
  int         checks = 0, errors = 0, n0;

  typedef struct {
    logic        m;
    logic [63:0] s;
    int          n;
    int          nw;
    logic [7:0]  w;
    logic        h;
  } vec_t;
  vec_t tv[6];

  entropy_whitener #(.WIDTH(8), .DEPTH(4), .REP_LIMIT(32)) dut (
    .clk(clk), .reset(reset), .raw_In(raw_In), .sample_En(sample_En), .mode(mode),
    .out_Ready(out_Ready), .out_Valid(out_Valid), .out_Data(out_Data),
    .overflow(overflow), .health_Fail(health_Fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!reset && out_Valid && out_Ready) q.push_back(out_Data);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_En = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic do_sample(input logic b);
    @(negedge clk);
    raw_In = b;
    repeat (2) @(negedge clk);
    sample_En = 1'b1;
    @(negedge clk);
    sample_En = 1'b0;
  endtask

  task automatic feed(input logic [63:0] s, input int n);
    for (int i = 0; i < n; i++) do_sample(s[i]);
  endtask

  task automatic chk_q(input string name, input int nw, input logic [7:0] w);
    chk({name, "_nwords"}, q.size(), nw);
    if (q.size() > 0) chk({name, "_word"}, q[q.size()-1], w);
  endtask

  initial begin
    tv[0] = '{1'b0, 64'h11111111, 32, 1, 8'hFF, 1'b0};
    tv[1] = '{1'b0, 64'h33333333, 32, 1, 8'h00, 1'b0};
    tv[2] = '{1'b0, 64'h13133131, 32, 1, 8'hA5, 1'b0};
    tv[3] = '{1'b1, 64'h6719C6,   24, 1, 8'hB6, 1'b0};
    tv[4] = '{1'b1, 64'hCCCC,     16, 0, 8'h00, 1'b0};
    tv[5] = '{1'b0, 64'hAAAAAAAA, 32, 1, 8'h00, 1'b0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_Valid, 0);
    chk("rst_data", out_Data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_health", health_Fail, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      out_Ready = 1'b1;
      mode = tv[i].m;
      repeat (2) @(negedge clk);
      feed(tv[i].s, tv[i].n);
      repeat (3) @(negedge clk);
      chk_q($sformatf("tv%0d", i), tv[i].nw, tv[i].w);
      chk($sformatf("tv%0d_health", i), health_Fail, tv[i].h);
      chk($sformatf("tv%0d_ovf", i), overflow, 0);
      chk($sformatf("tv%0d_valid_drop", i), out_Valid, 0);
    end

    mode = 1'b0;
    do_reset();
    out_Ready = 1'b0;
    feed(64'h11111111, 32);
    chk("bp_valid1", out_Valid, 1);
    chk("bp_data1", out_Data, 8'hFF);
    feed(64'h33333333, 32);
    chk("bp_hold_valid", out_Valid, 1);
    chk("bp_hold_data", out_Data, 8'hFF);
    chk("bp_ovf", overflow, 1);
    out_Ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_valid", out_Valid, 0);
    chk_q("bp", 1, 8'hFF);

    do_reset();
    out_Ready = 1'b0;
    feed(64'h11111111, 32);
    feed(64'h33333333, 31);
    @(negedge clk);
    raw_In = 1'b0;
    repeat (2) @(negedge clk);
    sample_En = 1'b1;
    out_Ready = 1'b1;
    @(negedge clk);
    sample_En = 1'b0;
    chk("nb_valid", out_Valid, 1);
    chk("nb_data", out_Data, 8'h00);
    chk("nb_ovf", overflow, 0);
    chk_q("nb_first", 1, 8'hFF);
    @(negedge clk);
    chk_q("nb_second", 2, 8'h00);
    chk("nb_valid_drop", out_Valid, 0);

    do_reset();
    feed(64'hFFFFFFFFFFFFFFFF, 31);
    chk("hl_31", health_Fail, 0);
    feed(64'h1, 1);
    chk("hl_32", health_Fail, 1);
    repeat (3) @(negedge clk);
    n0 = q.size();
    feed(64'hAAAAAAAA, 32);
    repeat (3) @(negedge clk);
    chk("hl_nowords", q.size(), n0);
    chk("hl_sticky", health_Fail, 1);
    chk("hl_valid", out_Valid, 0);

    do_reset();
    feed(64'h11111111, 14);
    @(negedge clk);
    mode = 1'b1;
    repeat (2) @(negedge clk);
    feed(64'h6719C6, 24);
    repeat (3) @(negedge clk);
    chk_q("ms", 1, 8'hB6);
    mode = 1'b0;

    do_reset();
    out_Ready = 1'b0;
    feed(64'h11111111, 32);
    feed(64'h33333333, 32);
    feed(64'h11111111, 12);
    chk("rs_pre_valid", out_Valid, 1);
    chk("rs_pre_ovf", overflow, 1);
    do_reset();
    chk("rs_valid", out_Valid, 0);
    chk("rs_data", out_Data, 0);
    chk("rs_ovf", overflow, 0);
    chk("rs_health", health_Fail, 0);
    out_Ready = 1'b1;
    feed(64'h13133131, 32);
    repeat (3) @(negedge clk);
    chk_q("rs", 1, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
